beam_scan_sad: RTL and testbench

BEAM_SCAN_SAD -- requirements
Module: beam_scan_sad

---
 rtl/beam_pkg.sv | 29 ++
 rtl/sad_accum.sv | 56 +++++
 rtl/beam_scan_sad.sv | 236 +++++++++++++++++++++++
 tb/tb_beam_scan_sad.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_pkg.sv
// ---------------------------------------------------------------------------
// beam_pkg
// Shared definitions for the beam-steering blocks.
//   beam_state_e : FILL / COMPUTE / REPORT state encoding
//   acc_width()  : SAD accumulator width (sample width + sign + log2(window))
//   lag_width()  : width of a lag index covering -max_lag..+max_lag
// ---------------------------------------------------------------------------
package beam_pkg;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_REPORT  = 2'd2
  } beam_state_e;

  // A difference needs one extra bit beyond the sample width, and summing
  // `win` magnitudes grows the result by at most clog2(win) bits.
  function automatic int acc_width(input int data_width, input int win);
    return data_width + 1 + $clog2(win);
  endfunction

  function automatic int lag_width(input int max_lag);
    return $clog2(2 * max_lag + 1);
  endfunction

  localparam int DEF_ACC_W = acc_width(16, 30);
  localparam int DEF_LAG_W = lag_width(30);

endpackage

// File: rtl/sad_accum.sv
// ---------------------------------------------------------------------------
// sad_accum
// Absolute-difference accumulator for one SAD lag.
//   clk, reset_n : clock, asynchronous active-low reset (clears sum)
//   clear        : restart the sum; with en it loads |a-b| directly
//   en           : accumulate |a-b| this cycle
//   a, b         : signed samples
//   sum          : registered running sum of magnitudes
// ---------------------------------------------------------------------------
module sad_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_W      = 21
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic        [ACC_W-1:0]      sum
);

  logic signed [DATA_WIDTH:0] diff;
  logic        [DATA_WIDTH:0] mag;
  logic        [ACC_W-1:0]    sum_d;
  logic        [ACC_W-1:0]    sum_q;

  // Sign-extend both operands so the subtraction can never wrap; the
  // negation of the most negative possible difference still fits unsigned.
  always_comb begin
    diff = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    mag  = diff[DATA_WIDTH] ? -diff : diff;
  end

  // Clear together with en loads the first term of a new lag, so
  // back-to-back lags need no idle cycle in between.
  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = en ? ACC_W'(mag) : '0;
    end else if (en) begin
      sum_d = sum_q + ACC_W'(mag);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/beam_scan_sad.sv
// ---------------------------------------------------------------------------
// beam_scan_sad
// Stereo time-delay estimator: collects a frame of left/right samples, scans
// all lags -MAX_LAG..+MAX_LAG with a sum-of-absolute-differences metric and
// reports the best lag plus a one-hot LED direction zone.
//   clk, reset_n                : clock, asynchronous active-low reset
//   left_data_in, right_data_in : signed sample pair
//   in_valid / in_ready         : sample handshake (ready only while filling)
//   out_valid / out_ready       : result handshake
//   lag_idx                     : best lag index, 0 means -MAX_LAG
//   min_sad                     : SAD at the best lag
//   led_pattern                 : one-hot zone of lag_idx
//   busy                        : high while the lag scan runs
// ---------------------------------------------------------------------------
module beam_scan_sad
  import beam_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int WIN        = 30,
  parameter  int MAX_LAG    = 30,
  parameter  int LED_WIDTH  = 8,
  localparam int NLAG       = 2 * MAX_LAG + 1,
  localparam int ACC_W      = acc_width(DATA_WIDTH, WIN),
  localparam int LAG_W      = lag_width(MAX_LAG)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] left_data_in,
  input  logic signed [DATA_WIDTH-1:0] right_data_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [LAG_W-1:0]      lag_idx,
  output logic        [ACC_W-1:0]      min_sad,
  output logic        [LED_WIDTH-1:0]  led_pattern,
  output logic                         busy
);

  localparam int NFRAME = WIN + 2 * MAX_LAG;
  localparam int ADDR_W = $clog2(NFRAME);
  localparam int J_W    = $clog2(WIN + 1);
  localparam int K_W    = $clog2(NLAG + 1);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NFRAME - 1);
  localparam logic [J_W-1:0]    J_LAST    = J_W'(WIN - 1);
  // k reaching NLAG marks the extra cycle that only compares the last lag.
  localparam logic [K_W-1:0]    K_END     = K_W'(NLAG);

  beam_state_e state_q, state_d;

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [J_W-1:0]       j_q, j_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [ACC_W-1:0]     best_sad_q, best_sad_d;
  logic [LAG_W-1:0]     best_lag_q, best_lag_d;
  logic [LAG_W-1:0]     lag_idx_q, lag_idx_d;
  logic [ACC_W-1:0]     min_sad_q, min_sad_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic                         xfer;
  logic                         wr_en;
  logic                         acc_clear;
  logic                         acc_en;
  logic        [ACC_W-1:0]      acc_sum;
  logic                         cmp_en;
  logic                         take_new;
  logic        [ACC_W-1:0]      new_sad;
  logic        [LAG_W-1:0]      new_lag;
  int                           led_zone;
  logic        [ADDR_W-1:0]     l_addr;
  logic        [ADDR_W-1:0]     r_addr;
  logic signed [DATA_WIDTH-1:0] l_rd;
  logic signed [DATA_WIDTH-1:0] r_rd;

  // Sample storage: one write port, one read port per channel, no reset.
  logic signed [DATA_WIDTH-1:0] l_mem [NFRAME];
  logic signed [DATA_WIDTH-1:0] r_mem [NFRAME];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      l_mem[wr_ptr_q] <= left_data_in;
      r_mem[wr_ptr_q] <= right_data_in;
    end
  end

  // The left window is fixed at the centre of the frame; the right window
  // slides with the lag. The address is parked at 0 on the compare-only cycle.
  always_comb begin
    l_addr = ADDR_W'(MAX_LAG) + ADDR_W'(j_q);
    r_addr = (k_q == K_END) ? '0 : ADDR_W'(j_q) + ADDR_W'(k_q);
  end

  assign l_rd = l_mem[l_addr];
  assign r_rd = r_mem[r_addr];

  sad_accum #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W)
  ) u_sad_accum (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (acc_clear),
    .en      (acc_en),
    .a       (l_rd),
    .b       (r_rd),
    .sum     (acc_sum)
  );

  // The accumulator holds the finished SAD of lag k-1 on the first cycle of
  // lag k (and on the compare-only cycle). Strict less-than keeps the
  // lowest lag on ties.
  always_comb begin
    cmp_en   = (state_q == ST_COMPUTE) && (j_q == '0) && (k_q != '0);
    take_new = cmp_en && (acc_sum < best_sad_q);
    new_sad  = take_new ? acc_sum : best_sad_q;
    new_lag  = take_new ? LAG_W'(k_q - K_W'(1)) : best_lag_q;
    led_zone = (int'(new_lag) * LED_WIDTH) / NLAG;
  end

  assign xfer = in_valid && in_ready_q && (state_q == ST_FILL);

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    j_d         = j_q;
    k_d         = k_q;
    best_sad_d  = best_sad_q;
    best_lag_d  = best_lag_q;
    lag_idx_d   = lag_idx_q;
    min_sad_d   = min_sad_q;
    led_d       = led_q;
    wr_en       = 1'b0;
    acc_clear   = 1'b0;
    acc_en      = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        acc_clear = 1'b1;
        if (xfer) begin
          wr_en = 1'b1;
          if (wr_ptr_q == ADDR_LAST) begin
            state_d    = ST_COMPUTE;
            wr_ptr_d   = '0;
            j_d        = '0;
            k_d        = '0;
            best_sad_d = '1;
            best_lag_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end

      ST_COMPUTE: begin
        best_sad_d = new_sad;
        best_lag_d = new_lag;
        if (k_q == K_END) begin
          state_d   = ST_REPORT;
          lag_idx_d = new_lag;
          min_sad_d = new_sad;
          led_d     = LED_WIDTH'(1) << led_zone;
        end else begin
          acc_en    = 1'b1;
          acc_clear = (j_q == '0);
          if (j_q == J_LAST) begin
            j_d = '0;
            k_d = k_q + K_W'(1);
          end else begin
            j_d = j_q + J_W'(1);
          end
        end
      end

      ST_REPORT: begin
        if (out_ready) begin
          state_d  = ST_FILL;
          wr_ptr_d = '0;
        end
      end

      default: begin
        state_d  = ST_FILL;
        wr_ptr_d = '0;
      end
    endcase

    in_ready_d  = (state_d == ST_FILL);
    out_valid_d = (state_d == ST_REPORT);
    busy_d      = (state_d == ST_COMPUTE);
  end

  // Handshake flags are registered from the next state, so in_ready only
  // rises on the first edge after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      j_q         <= '0;
      k_q         <= '0;
      best_sad_q  <= '1;
      best_lag_q  <= '0;
      lag_idx_q   <= '0;
      min_sad_q   <= '0;
      led_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      j_q         <= j_d;
      k_q         <= k_d;
      best_sad_q  <= best_sad_d;
      best_lag_q  <= best_lag_d;
      lag_idx_q   <= lag_idx_d;
      min_sad_q   <= min_sad_d;
      led_q       <= led_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign lag_idx     = lag_idx_q;
  assign min_sad     = min_sad_q;
  assign led_pattern = led_q;

endmodule

// File: tb/tb_beam_scan_sad.sv
// ---------------------------------------------------------------------------
// tb_beam_scan_sad
// Self-checking bench for beam_scan_sad with WIN=4, MAX_LAG=2, LED_WIDTH=5.
// Frames come from directed patterns and $urandom; a behavioural SAD search
// over the frame arrays supplies the expected result.
// ---------------------------------------------------------------------------
module tb_beam_scan_sad;

  localparam int DW      = 16;
  localparam int WIN     = 4;
  localparam int MAX_LAG = 2;
  localparam int LEDW    = 5;
  localparam int NLAG    = 2 * MAX_LAG + 1;
  localparam int NFRAME  = WIN + 2 * MAX_LAG;
  localparam int ACC_W   = DW + 1 + $clog2(WIN);
  localparam int LAG_W   = $clog2(NLAG);

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic signed [DW-1:0] left_data_in = '0;
  logic signed [DW-1:0] right_data_in = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [LAG_W-1:0]     lag_idx;
  logic [ACC_W-1:0]     min_sad;
  logic [LEDW-1:0]      led_pattern;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  int fl [NFRAME];
  int fr [NFRAME];

  int            exp_lag;
  int            exp_sad;
  logic [LEDW-1:0] exp_led;
  bit            exp_pending = 1'b0;

  beam_scan_sad #(
    .DATA_WIDTH (DW),
    .WIN        (WIN),
    .MAX_LAG    (MAX_LAG),
    .LED_WIDTH  (LEDW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .left_data_in  (left_data_in),
    .right_data_in (right_data_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .lag_idx       (lag_idx),
    .min_sad       (min_sad),
    .led_pattern   (led_pattern),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a FAIL line on disagreement.
  task automatic check_output(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: exhaustive SAD over every lag, first strict minimum wins.
  function automatic void model(output int lag, output int sad);
    longint best;
    longint s;
    longint d;
    best = 64'h7fff_ffff_ffff;
    lag  = 0;
    for (int k = 0; k < NLAG; k++) begin
      s = 0;
      for (int j = 0; j < WIN; j++) begin
        d = longint'(fl[MAX_LAG + j]) - longint'(fr[j + k]);
        s += (d < 0) ? -d : d;
      end
      if (s < best) begin
        best = s;
        lag  = k;
      end
    end
    sad = int'(best);
  endfunction

  // Checks the result every cycle the DUT reports one.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (!exp_pending) begin
        check_output("unexpected_out_valid", 1, 0);
      end else begin
        check_output("lag_idx", longint'(lag_idx), longint'(exp_lag));
        check_output("min_sad", longint'(min_sad), longint'(exp_sad));
        check_output("led_pattern", longint'(led_pattern), longint'(exp_led));
        check_output("in_ready_in_report", longint'(in_ready), 0);
        check_output("busy_in_report", longint'(busy), 0);
      end
    end
  end

  task automatic send_frame();
    int w;
    for (int i = 0; i < NFRAME; i++) begin
      left_data_in  = DW'(fl[i]);
      right_data_in = DW'(fr[i]);
      in_valid      = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
        w++;
        @(negedge clk);
      end
      if (w >= 50) check_output("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Sends fl/fr, waits for the result while throwing noise at the
  // handshakes, holds the result `hold` cycles, then acknowledges it.
  task automatic apply_stimulus(input int hold, input bit chk_lat);
    int lag;
    int sad;
    int lat;
    model(lag, sad);
    exp_lag     = lag;
    exp_sad     = sad;
    exp_led     = LEDW'(1) << ((lag * LEDW) / NLAG);
    exp_pending = 1'b1;
    send_frame();
    lat = 0;
    while (!out_valid && lat < 500) begin
      in_valid      = 1'($urandom_range(0, 1));
      left_data_in  = DW'($urandom);
      right_data_in = DW'($urandom);
      out_ready     = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid) begin
        check_output("busy_in_compute", longint'(busy), 1);
        check_output("in_ready_in_compute", longint'(in_ready), 0);
      end
    end
    out_ready = 1'b0;
    if (!out_valid) check_output("out_valid_timeout", 0, 1);
    if (chk_lat) check_output("latency", lat, NLAG * WIN + 1);
    repeat (hold) begin
      in_valid      = 1'($urandom_range(0, 1));
      left_data_in  = DW'($urandom);
      right_data_in = DW'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready   = 1'b0;
    exp_pending = 1'b0;
    check_output("out_valid_after_ack", longint'(out_valid), 0);
    check_output("in_ready_after_ack", longint'(in_ready), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_out_valid"}, longint'(out_valid), 0);
    check_output({tag, "_in_ready"}, longint'(in_ready), 0);
    check_output({tag, "_busy"}, longint'(busy), 0);
    check_output({tag, "_lag_idx"}, longint'(lag_idx), 0);
    check_output({tag, "_min_sad"}, longint'(min_sad), 0);
    check_output({tag, "_led"}, longint'(led_pattern), 0);
  endtask

  task automatic pin_model(input string name, input int lag_req, input int sad_req);
    int lag;
    int sad;
    model(lag, sad);
    check_output({name, "_model_lag"}, lag, lag_req);
    check_output({name, "_model_sad"}, sad, sad_req);
  endtask

  initial begin
    #12;
    check_reset_values("reset");
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("in_ready_after_reset", longint'(in_ready), 1);

    // Identical ramp: zero SAD at the centre lag, with latency check.
    for (int i = 0; i < NFRAME; i++) begin
      fl[i] = i;
      fr[i] = i;
    end
    pin_model("ramp", 2, 0);
    apply_stimulus(10, 1'b1);

    // Impulse: right channel one sample behind the left.
    for (int i = 0; i < NFRAME; i++) begin
      fl[i] = 0;
      fr[i] = 0;
    end
    fl[3] = 100;
    fr[4] = 100;
    pin_model("impulse", 3, 0);
    apply_stimulus(3, 1'b1);

    // Abort a frame mid-scan; only the following frame may report.
    for (int i = 0; i < NFRAME; i++) begin
      fl[i] = int'($urandom_range(0, 200)) - 100;
      fr[i] = int'($urandom_range(0, 200)) - 100;
    end
    send_frame();
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    check_output("in_ready_held_in_reset", longint'(in_ready), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("in_ready_after_midreset", longint'(in_ready), 1);
    for (int i = 0; i < NFRAME; i++) begin
      fl[i] = 5 * i;
      fr[i] = 5 * i + 1;
    end
    pin_model("offset", 2, 4);
    apply_stimulus(2, 1'b1);

    // All-zero frame: tie everywhere, lowest lag wins.
    for (int i = 0; i < NFRAME; i++) begin
      fl[i] = 0;
      fr[i] = 0;
    end
    pin_model("zeros", 0, 0);
    apply_stimulus(1, 1'b1);

    // Full-scale opposite extremes: largest possible SAD.
    for (int i = 0; i < NFRAME; i++) begin
      fl[i] = 32767;
      fr[i] = -32768;
    end
    pin_model("fullscale", 0, 262140);
    apply_stimulus(0, 1'b1);

    // Random frames: small ranges provoke ties, wide ranges stress widths.
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NFRAME; i++) begin
        if (f < 5) begin
          fl[i] = int'($urandom_range(0, 3));
          fr[i] = int'($urandom_range(0, 3));
        end else begin
          fl[i] = int'($urandom_range(0, 65535)) - 32768;
          fr[i] = int'($urandom_range(0, 65535)) - 32768;
        end
      end
      apply_stimulus(int'($urandom_range(0, 4)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
